// File: rtl/ssr_reset_sequencer.sv
// Board-level reset sequencer: waits for a stable clock lock and a debounced button,
// then releases the domain resets one at a time and runs a heartbeat LED.
module ssr_reset_sequencer #(
    parameter int N_DOMAINS          = 2,
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int STAGE_GAP_CYCLES   = 16,
    parameter int DEBOUNCE_CYCLES    = 1000000,
    parameter int HEARTBEAT_DIV      = 50000000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 btn_rst,
    input  logic                 locked,
    output logic [N_DOMAINS-1:0] rst_out,
    output logic                 ready,
    output logic                 led_status,
    output logic [1:0]           state_dbg
);

    localparam logic [1:0] WAIT_LOCK   = 2'd0;
    localparam logic [1:0] LOCK_STABLE = 2'd1;
    localparam logic [1:0] RELEASE     = 2'd2;
    localparam logic [1:0] RUN         = 2'd3;

    localparam int STAB_W = (LOCK_STABLE_CYCLES > 1) ? $clog2(LOCK_STABLE_CYCLES) : 1;
    localparam int GAP_W  = (STAGE_GAP_CYCLES > 1) ? $clog2(STAGE_GAP_CYCLES) : 1;
    localparam int DB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int HB_W   = (HEARTBEAT_DIV > 1) ? $clog2(HEARTBEAT_DIV) : 1;
    localparam int IDX_W  = (N_DOMAINS > 1) ? $clog2(N_DOMAINS) : 1;

    // The WAIT_LOCK exit edge already counts as the first stable cycle.
    localparam logic [STAB_W-1:0] STAB_LAST =
        STAB_W'((LOCK_STABLE_CYCLES >= 2) ? (LOCK_STABLE_CYCLES - 2) : 0);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(STAGE_GAP_CYCLES - 1);
    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HB_W-1:0]   HB_LAST   = HB_W'(HEARTBEAT_DIV - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(N_DOMAINS - 1);

    logic                 locked_m, locked_s;
    logic                 btn_m, btn_s;
    logic                 btn_db;
    logic [DB_W-1:0]      db_cnt;

    logic [1:0]           state;
    logic [STAB_W-1:0]    stab_cnt;
    logic [GAP_W-1:0]     gap_cnt;
    logic [IDX_W-1:0]     idx;
    logic [HB_W-1:0]      hb_cnt;
    logic [N_DOMAINS-1:0] rst_q;
    logic                 ready_q;
    logic                 led_q;

    logic                 abort;
    logic                 start_ok;
    logic [N_DOMAINS-1:0] release_mask;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            locked_m <= 1'b0;
            locked_s <= 1'b0;
            btn_m    <= 1'b0;
            btn_s    <= 1'b0;
        end else begin
            locked_m <= locked;
            locked_s <= locked_m;
            btn_m    <= btn_rst;
            btn_s    <= btn_m;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_db <= 1'b0;
            db_cnt <= '0;
        end else if (btn_s == btn_db) begin
            db_cnt <= '0;
        end else if (db_cnt == DB_LAST) begin
            btn_db <= btn_s;
            db_cnt <= '0;
        end else begin
            db_cnt <= db_cnt + 1'b1;
        end
    end

    assign start_ok = locked_s && !btn_db;
    assign abort    = (state != WAIT_LOCK) && !start_ok;

    always_comb begin
        release_mask = '0;
        for (int i = 0; i < N_DOMAINS; i++) begin
            release_mask[i] = (idx == IDX_W'(i));
        end
    end

    // Abort outranks every transition, including the final release edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= WAIT_LOCK;
            stab_cnt <= '0;
            gap_cnt  <= '0;
            idx      <= '0;
            hb_cnt   <= '0;
            rst_q    <= '1;
            ready_q  <= 1'b0;
            led_q    <= 1'b0;
        end else if (abort) begin
            state    <= WAIT_LOCK;
            stab_cnt <= '0;
            gap_cnt  <= '0;
            idx      <= '0;
            hb_cnt   <= '0;
            rst_q    <= '1;
            ready_q  <= 1'b0;
            led_q    <= 1'b0;
        end else begin
            case (state)
                WAIT_LOCK: begin
                    rst_q   <= '1;
                    ready_q <= 1'b0;
                    led_q   <= 1'b0;
                    if (start_ok) begin
                        stab_cnt <= '0;
                        gap_cnt  <= '0;
                        idx      <= '0;
                        led_q    <= 1'b1;
                        state    <= (LOCK_STABLE_CYCLES == 1) ? RELEASE : LOCK_STABLE;
                    end
                end
                LOCK_STABLE: begin
                    if (stab_cnt == STAB_LAST) begin
                        stab_cnt <= '0;
                        gap_cnt  <= '0;
                        idx      <= '0;
                        state    <= RELEASE;
                    end else begin
                        stab_cnt <= stab_cnt + 1'b1;
                    end
                end
                RELEASE: begin
                    if (gap_cnt == GAP_LAST) begin
                        gap_cnt <= '0;
                        rst_q   <= rst_q & ~release_mask;
                        if (idx == IDX_LAST) begin
                            idx     <= '0;
                            hb_cnt  <= '0;
                            ready_q <= 1'b1;
                            led_q   <= 1'b1;
                            state   <= RUN;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                RUN: begin
                    if (hb_cnt == HB_LAST) begin
                        hb_cnt <= '0;
                        led_q  <= ~led_q;
                    end else begin
                        hb_cnt <= hb_cnt + 1'b1;
                    end
                end
                default: state <= WAIT_LOCK;
            endcase
        end
    end

    assign rst_out    = rst_q;
    assign ready      = ready_q;
    assign led_status = led_q;
    assign state_dbg  = state;

endmodule

// File: tb/tb_ssr_reset_sequencer.sv
// Bench for ssr_reset_sequencer: directed bring-up/abort scenarios plus random
// lock/button activity, all checked against a run-length model of the sequencer.
module tb_ssr_reset_sequencer;

    localparam int N     = 3;
    localparam int L     = 8;
    localparam int G     = 4;
    localparam int D     = 5;
    localparam int HB    = 6;
    localparam int RUN_N = L + N * G;
    localparam int SAT   = 1 << 30;

    logic         clk = 1'b0;
    logic         rst;
    logic         btn_rst;
    logic         locked;
    logic [N-1:0] rst_out;
    logic         ready;
    logic         led_status;
    logic [1:0]   state_dbg;

    int vectors    = 0;
    int miscompares = 0;
    int edge_cnt   = 0;

    ssr_reset_sequencer #(
        .N_DOMAINS(N),
        .LOCK_STABLE_CYCLES(L),
        .STAGE_GAP_CYCLES(G),
        .DEBOUNCE_CYCLES(D),
        .HEARTBEAT_DIV(HB)
    ) dut (
        .clk(clk),
        .rst(rst),
        .btn_rst(btn_rst),
        .locked(locked),
        .rst_out(rst_out),
        .ready(ready),
        .led_status(led_status),
        .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: actual %0d required %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: everything follows from n, the number of consecutive edges that
    // sampled "lock synchronised high and debounced button low".
    function automatic logic [6:0] expect_vec(input int k);
        logic [N-1:0] r;
        logic rd, ld;
        logic [1:0] st;
        for (int i = 0; i < N; i++) r[i] = (k < L + (i + 1) * G);
        rd = (k >= RUN_N);
        if (k == 0) begin
            st = 2'd0; ld = 1'b0;
        end else if (k < L) begin
            st = 2'd1; ld = 1'b1;
        end else if (k < RUN_N) begin
            st = 2'd2; ld = 1'b1;
        end else begin
            st = 2'd3; ld = (((k - RUN_N) / HB) % 2) == 0;
        end
        return {r, rd, ld, st};
    endfunction

    int   n = 0;
    bit   ls1, ls2, bs1, bs2, db;
    bit   bhist[$];
    logic [6:0] exp_q[$];

    always @(posedge clk or posedge rst) begin
        bit ok, all_diff;
        if (rst) begin
            n = 0; ls1 = 0; ls2 = 0; bs1 = 0; bs2 = 0; db = 0;
            bhist.delete();
            exp_q.delete();
            exp_q.push_back(expect_vec(0));
        end else begin
            ok = ls2 && !db;
            n  = ok ? ((n < SAT) ? n + 1 : n) : 0;
            // the debounced level flips once the last D samples all disagree with it
            bhist.push_back(bs2);
            if (bhist.size() > D) void'(bhist.pop_front());
            if (bhist.size() == D) begin
                all_diff = 1;
                foreach (bhist[k]) if (bhist[k] == db) all_diff = 0;
                if (all_diff) db = !db;
            end
            ls2 = ls1; ls1 = locked;
            bs2 = bs1; bs1 = btn_rst;
            exp_q.push_back(expect_vec(n));
        end
    end

    always @(negedge clk) begin
        logic [6:0] e;
        if (exp_q.size() == 0) begin
            check("scoreboard empty", 32'(0), 32'(1));
        end else begin
            e = exp_q.pop_front();
            check("rst_out", 32'(rst_out), 32'(e[6:4]));
            check("ready", 32'(ready), 32'(e[3]));
            check("led_status", 32'(led_status), 32'(e[2]));
            check("state_dbg", 32'(state_dbg), 32'(e[1:0]));
        end
    end

    // Edge markers for the hand-computed timing checks.
    int   fall_edge[N];
    int   ready_edge, allset_edge, leave_edge;
    logic [N-1:0] prev_r = '1;
    logic prev_ready = 1'b0;
    logic [1:0] prev_st = 2'd0;

    always @(posedge clk) begin
        edge_cnt++;
        #1;
        for (int i = 0; i < N; i++)
            if (prev_r[i] && !rst_out[i]) fall_edge[i] = edge_cnt;
        if (!prev_ready && ready) ready_edge = edge_cnt;
        if (prev_r != '1 && rst_out == '1) allset_edge = edge_cnt;
        if (prev_st == 2'd0 && state_dbg != 2'd0) leave_edge = edge_cnt;
        prev_r = rst_out; prev_ready = ready; prev_st = state_dbg;
    end

    task automatic clear_marks();
        for (int i = 0; i < N; i++) fall_edge[i] = 0;
        ready_edge = 0; allset_edge = 0; leave_edge = 0;
    endtask

    task automatic wait_ready(input int budget, input string tag);
        for (int i = 0; i < budget && ready !== 1'b1; i++) @(negedge clk);
        check({tag, " ready timeout"}, 32'(ready), 32'(1));
    endtask

    task automatic check_schedule(input int e, input string tag);
        check({tag, " rst_out0 fall edge"}, 32'(fall_edge[0]), 32'(e + 13));
        check({tag, " rst_out1 fall edge"}, 32'(fall_edge[1]), 32'(e + 17));
        check({tag, " rst_out2 fall edge"}, 32'(fall_edge[2]), 32'(e + 21));
        check({tag, " ready rise edge"}, 32'(ready_edge), 32'(e + 21));
        check({tag, " state RUN"}, 32'(state_dbg), 32'(3));
    endtask

    initial begin
        int e, p, r, f;
        rst = 1'b1; locked = 1'b0; btn_rst = 1'b0;
        clear_marks();
        repeat (3) @(negedge clk);
        check("reset rst_out", 32'(rst_out), 32'(7));
        check("reset ready", 32'(ready), 32'(0));
        check("reset led", 32'(led_status), 32'(0));
        check("reset state", 32'(state_dbg), 32'(0));
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // Nominal bring-up
        clear_marks();
        locked = 1'b1; e = edge_cnt + 1;
        wait_ready(60, "nominal");
        check_schedule(e, "nominal");

        // Heartbeat: 1 for the first 6 RUN cycles, then 0, then 1
        check("heartbeat phase0", 32'(led_status), 32'(1));
        repeat (6) @(negedge clk);
        check("heartbeat phase1", 32'(led_status), 32'(0));
        repeat (6) @(negedge clk);
        check("heartbeat phase2", 32'(led_status), 32'(1));

        // Short button glitch is ignored
        btn_rst = 1'b1;
        repeat (3) @(negedge clk);
        btn_rst = 1'b0;
        repeat (12) @(negedge clk);
        check("glitch keeps ready", 32'(ready), 32'(1));
        check("glitch keeps RUN", 32'(state_dbg), 32'(3));

        // 10-cycle press: abort on the 8th edge counting the sampling edge p
        clear_marks();
        btn_rst = 1'b1; p = edge_cnt + 1;
        repeat (10) @(negedge clk);
        check("press abort edge", 32'(allset_edge), 32'(p + 7));
        check("press holds WAIT_LOCK", 32'(state_dbg), 32'(0));
        btn_rst = 1'b0; r = edge_cnt + 1;
        for (int i = 0; i < 30 && state_dbg == 2'd0; i++) @(negedge clk);
        check("release exit edge", 32'(leave_edge), 32'(r + 7));
        wait_ready(40, "after press");

        // Lock loss while RELEASE is in progress
        locked = 1'b0;
        repeat (5) @(negedge clk);
        locked = 1'b1;
        for (int i = 0; i < 40 && rst_out[0] !== 1'b0; i++) @(negedge clk);
        check("lockloss rst_out0 released", 32'(rst_out[0]), 32'(0));
        clear_marks();
        locked = 1'b0; f = edge_cnt + 1;
        repeat (4) @(negedge clk);
        check("lockloss abort edge", 32'(allset_edge), 32'(f + 2));
        check("lockloss rst_out", 32'(rst_out), 32'(7));
        check("lockloss state", 32'(state_dbg), 32'(0));
        clear_marks();
        locked = 1'b1; e = edge_cnt + 1;
        wait_ready(60, "resequence");
        check_schedule(e, "resequence");

        // Lock loss reaching the FSM on the final release edge
        locked = 1'b0;
        repeat (5) @(negedge clk);
        clear_marks();
        locked = 1'b1; e = edge_cnt + 1;
        for (int i = 0; i < 40 && edge_cnt < e + 18; i++) @(negedge clk);
        locked = 1'b0;
        repeat (10) @(negedge clk);
        check("simul rst_out1 fall edge", 32'(fall_edge[1]), 32'(e + 17));
        check("simul rst_out2 never falls", 32'(fall_edge[2]), 32'(0));
        check("simul ready never rises", 32'(ready_edge), 32'(0));
        check("simul rst_out", 32'(rst_out), 32'(7));
        check("simul state", 32'(state_dbg), 32'(0));

        // Random lock/button activity against the model
        for (int s = 0; s < 120; s++) begin
            locked  = ($urandom_range(0, 3) != 0);
            btn_rst = ($urandom_range(0, 7) == 0);
            repeat ($urandom_range(1, btn_rst ? 9 : 40)) @(negedge clk);
        end
        btn_rst = 1'b0; locked = 1'b1;
        wait_ready(120, "after random");

        // Asynchronous reset in RUN takes effect without a clock edge
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("async rst_out", 32'(rst_out), 32'(7));
        check("async ready", 32'(ready), 32'(0));
        check("async led", 32'(led_status), 32'(0));
        check("async state", 32'(state_dbg), 32'(0));
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
